// File: rtl/soft_error_reg_model.sv
// WIDTH-bit register that can corrupt its word at capture: random upsets from an internal LFSR, plus directed single-bit flips.
// Latency d->q is 1 cycle; a directed request is held off (inject_ready low) while one is pending.
module soft_error_reg_model #(
  parameter int          WIDTH     = 8,
  parameter int          BURST_LEN = 2,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001,
  parameter int          COUNT_W   = 16,
  localparam int         IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q,
  input  logic [1:0]         mode,
  input  logic [19:0]        rate,
  input  logic               inject_valid,
  input  logic [IDX_W-1:0]   inject_idx,
  output logic               inject_ready,
  input  logic               seed_load,
  input  logic [31:0]        seed,
  output logic               err_pulse,
  output logic [COUNT_W-1:0] err_count,
  input  logic               clr_count
);

  localparam logic [31:0]      TAPS = 32'h8020_0003;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [31:0]      lfsr;
  logic [31:0]      lfsr_step;
  logic             hit;
  int               pos;
  int               bit_i;
  logic [WIDTH-1:0] rand_mask;
  logic [WIDTH-1:0] dir_mask;
  logic             any_err;
  logic             pending;
  logic [IDX_W-1:0] pending_idx;
  logic [IDX_W-1:0] idx_mod;

  assign lfsr_step    = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign hit          = (lfsr[19:0] < rate);
  assign inject_ready = !pending;
  assign idx_mod      = IDX_W'(32'(inject_idx) % WIDTH);
  assign dir_mask     = pending ? (ONE << pending_idx) : '0;
  assign any_err      = |(rand_mask | dir_mask);

  // Burst bits wrap past the top back to bit 0; pos < WIDTH so one subtract suffices.
  always_comb begin
    rand_mask = '0;
    bit_i     = 0;
    pos       = int'({20'd0, lfsr[31:20]}) % WIDTH;
    if (hit && mode == 2'd1) begin
      rand_mask = ONE << pos;
    end else if (hit && mode == 2'd2) begin
      for (int k = 0; k < BURST_LEN; k++) begin
        bit_i = pos + k;
        if (bit_i >= WIDTH) bit_i = bit_i - WIDTH;
        rand_mask = rand_mask | (ONE << bit_i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else if (seed_load) begin
      lfsr <= (seed == 32'd0) ? 32'd1 : seed;
    end else begin
      lfsr <= lfsr_step;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q         <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= en && any_err;
      if (en) q <= d ^ rand_mask ^ dir_mask;
    end
  end

  // A request can only be accepted while idle, so it never shares an edge with its own consumption.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      pending_idx <= '0;
    end else if (pending) begin
      if (en) pending <= 1'b0;
    end else if (inject_valid) begin
      pending     <= 1'b1;
      pending_idx <= idx_mod;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (en && any_err && (err_count != '1)) begin
      err_count <= err_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_soft_error_reg_model.sv
// Bench for soft_error_reg_model: directed steps plus randomized traffic against a cycle-level reference model.
module tb_soft_error_reg_model;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        en;
  logic [7:0]  d;
  logic [7:0]  q;
  logic [1:0]  mode;
  logic [19:0] rate;
  logic        inject_valid;
  logic [2:0]  inject_idx;
  logic        inject_ready;
  logic        seed_load;
  logic [31:0] seed;
  logic        err_pulse;
  logic [3:0]  err_count;
  logic        clr_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_lfsr;
  logic [7:0]  m_q;
  logic        m_pend;
  int          m_pidx;
  logic        m_pulse;
  int          m_cnt;

  logic [7:0]  trace_a [40];

  always #5 clock = ~clock;

  soft_error_reg_model #(
    .WIDTH(8), .BURST_LEN(3), .LFSR_SEED(32'hACE1_0001), .COUNT_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .d(d), .q(q), .mode(mode), .rate(rate),
    .inject_valid(inject_valid), .inject_idx(inject_idx), .inject_ready(inject_ready),
    .seed_load(seed_load), .seed(seed), .err_pulse(err_pulse), .err_count(err_count),
    .clr_count(clr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Multiplying by x modulo x^32+x^22+x^2+x+1, in the right-shifting bit order.
  function automatic logic [31:0] poly_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
    return n;
  endfunction

  task automatic reset_model();
    m_lfsr  = 32'hACE1_0001;
    m_q     = 8'h00;
    m_pend  = 1'b0;
    m_pidx  = 0;
    m_pulse = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic tick();
    logic [7:0]  rm, dm, n_q;
    logic [31:0] n_lfsr;
    logic        hit, n_pend, n_pulse;
    int          p, n_pidx, n_cnt;
    rm = 8'h00;
    dm = 8'h00;
    hit = (m_lfsr[19:0] < rate);
    p = int'(m_lfsr[31:20]) % 8;
    if (hit && mode == 2'd1) rm = 8'(1 << p);
    if (hit && mode == 2'd2)
      for (int k = 0; k < 3; k++) rm = rm | 8'(1 << ((p + k) % 8));
    if (m_pend) dm = 8'(1 << m_pidx);
    n_q = m_q; n_pend = m_pend; n_pidx = m_pidx; n_pulse = 1'b0; n_cnt = m_cnt;
    if (en) begin
      n_q = d ^ rm ^ dm;
      n_pulse = ((rm | dm) != 8'h00);
      if (m_pend) n_pend = 1'b0;
    end
    if (!m_pend && inject_valid) begin
      n_pend = 1'b1;
      n_pidx = int'(inject_idx) % 8;
    end
    if (clr_count) n_cnt = 0;
    else if (n_pulse && m_cnt < 15) n_cnt = m_cnt + 1;
    n_lfsr = seed_load ? ((seed == 32'd0) ? 32'd1 : seed) : poly_next(m_lfsr);
    @(posedge clock);
    #1;
    m_lfsr = n_lfsr; m_q = n_q; m_pend = n_pend; m_pidx = n_pidx;
    m_pulse = n_pulse; m_cnt = n_cnt;
  endtask

  task automatic check_all();
    check("q", 32'(q), 32'(m_q));
    check("pulse", 32'(err_pulse), 32'(m_pulse));
    check("count", 32'(err_count), 32'(m_cnt));
    check("ready", 32'(inject_ready), 32'(!m_pend));
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; d = 8'h00; mode = 2'd0; rate = 20'd0;
    inject_valid = 1'b0; inject_idx = 3'd0; seed_load = 1'b0; seed = 32'd0; clr_count = 1'b0;
    reset_model();
    #2;
    check("rst_q", 32'(q), 32'h0);
    check("rst_ready", 32'(inject_ready), 32'h1);
    check("rst_pulse", 32'(err_pulse), 32'h0);
    check("rst_count", 32'(err_count), 32'h0);
    reset_n = 1'b1;

    // Mode off: plain register
    mode = 2'd0; en = 1'b1; d = 8'h5A; rate = 20'hFFFFF;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("off_q", 32'(q), 32'h5A);
      check("off_pulse", 32'(err_pulse), 32'h0);
    end
    check("off_count", 32'(err_count), 32'h0);

    // Directed flip of bit 3
    mode = 2'd3; en = 1'b0; inject_valid = 1'b1; inject_idx = 3'd3;
    tick();
    check("dir_ready_low", 32'(inject_ready), 32'h0);
    inject_valid = 1'b0; en = 1'b1; d = 8'h00;
    tick();
    check("dir_q", 32'(q), 32'h08);
    check("dir_pulse", 32'(err_pulse), 32'h1);
    check("dir_ready_back", 32'(inject_ready), 32'h1);
    check("dir_count", 32'(err_count), 32'h1);
    tick();
    check("dir_once", 32'(q), 32'h00);
    check_all();

    // Burst from pos 7 wraps to bits 7,0,1
    en = 1'b0; seed_load = 1'b1; seed = 32'h0070_0000;
    tick();
    seed_load = 1'b0; mode = 2'd2; rate = 20'hFFFFF; en = 1'b1; d = 8'h00;
    tick();
    check("burst_wrap", 32'(q), 32'h83);
    check_all();

    // Single-bit upsets on nearly every capture; counter saturates
    en = 1'b0; mode = 2'd1; seed_load = 1'b1; seed = 32'h1234_5678;
    tick();
    seed_load = 1'b0; en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      check_all();
    end
    check("sat_count", 32'(err_count), 32'hF);
    clr_count = 1'b1;
    tick();
    check("clr_priority", 32'(err_count), 32'h0);
    check("clr_pulse", 32'(err_pulse), 32'(m_pulse));
    clr_count = 1'b0;

    // Reproducibility from a reloaded seed
    for (int run = 0; run < 2; run++) begin
      en = 1'b0; mode = 2'd1; rate = 20'h40000; seed_load = 1'b1; seed = 32'h0BAD_F00D;
      tick();
      seed_load = 1'b0; en = 1'b1;
      for (int i = 0; i < 40; i++) begin
        d = 8'(i * 37);
        tick();
        check_all();
        if (run == 0) trace_a[i] = q;
        else check("repro", 32'(q), 32'(trace_a[i]));
      end
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: rate = 20'd0;
        1: rate = 20'hFFFFF;
        default: rate = 20'($urandom);
      endcase
      inject_valid = ($urandom_range(0, 2) == 0);
      inject_idx = 3'($urandom_range(0, 7));
      seed_load = ($urandom_range(0, 30) == 0);
      seed = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
      clr_count = ($urandom_range(0, 20) == 0);
      tick();
      check_all();
    end

    // Reset while an injection is pending
    clr_count = 1'b0; seed_load = 1'b0; en = 1'b1; d = 8'hC3; mode = 2'd0;
    tick();
    en = 1'b0; inject_valid = 1'b1; inject_idx = 3'd5;
    tick();
    check("pend_ready", 32'(inject_ready), 32'h0);
    inject_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_q", 32'(q), 32'h0);
    check("mid_rst_ready", 32'(inject_ready), 32'h1);
    check("mid_rst_count", 32'(err_count), 32'h0);
    reset_model();
    #1;
    reset_n = 1'b1;
    mode = 2'd3; en = 1'b1; d = 8'h00;
    tick();
    check("post_rst_q", 32'(q), 32'h0);
    check("post_rst_pulse", 32'(err_pulse), 32'h0);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soft_error_reg_model.md
Name: soft_error_reg_model

Overview:
Simulation-oriented register model that captures a WIDTH-bit word and injects soft errors at capture time. Random upsets come from an internal, seedable 32-bit LFSR, so runs are reproducible without host calls. Adds runtime-selectable modes (off / random single-bit / random burst), a directed-injection handshake, and a saturating error counter. It replaces plain flops in fault-injection builds of datapath registers.

Parameters:
WIDTH, 8, data width in bits (1..4096)
BURST_LEN, 2, adjacent bits flipped per burst upset (1..WIDTH)
LFSR_SEED, 32'hACE1_0001, LFSR reset value (must be nonzero)
COUNT_W, 16, error counter width

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
en  input  1  capture enable; q updates only when high
d  input  WIDTH  data in
q  output  WIDTH  registered data out, possibly corrupted
mode  input  2  0=off, 1=random single-bit, 2=random burst, 3=directed only
rate  input  20  upset probability per enabled capture, in units of 1/2^20
inject_valid  input  1  directed-injection request
inject_idx  input  clog2(WIDTH) (min 1)  bit to flip on directed injection
inject_ready  output  1  high when no directed injection is pending
seed_load  input  1  load seed into LFSR this cycle
seed  input  32  LFSR seed value
err_pulse  output  1  one-cycle strobe: the capture on the previous edge was corrupted
err_count  output  COUNT_W  saturating count of corrupted captures
clr_count  input  1  synchronous clear of err_count

Behaviour:
- Reset (reset_n low, async): q=0, lfsr=LFSR_SEED, pending=0, inject_ready=1, err_pulse=0, err_count=0.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, advances every cycle regardless of en or mode. On seed_load it loads seed instead of advancing; seed==0 loads 32'h1. LFSR never reaches 0.
- Draw per cycle: r = lfsr[19:0]; hit = (r < rate); pos = lfsr[31:20] mod WIDTH. rate=0 never hits; rate=20'hFFFFF hits on all but r=20'hFFFFF.
- Random mask: mode 1 and hit -> one-hot bit pos. Mode 2 and hit -> BURST_LEN consecutive bits from pos upward, wrapping modulo WIDTH (WIDTH=8, BURST_LEN=3, pos=7 -> bits 7,0,1). Mode 0 or 3, or no hit -> 0.
- Directed: inject_valid && inject_ready accepts inject_idx into pending; inject_ready drops the next cycle. inject_idx >= WIDTH is reduced mod WIDTH. Accepted in any mode, including 0.
- Capture on an edge with en=1: q <= d ^ rand_mask ^ dir_mask, where dir_mask = one-hot(pending_idx) if pending was set before this edge, else 0. Pending clears on that edge and inject_ready returns high the next cycle. A request accepted on the same edge applies at the next enabled capture, not this one.
- Coinciding directed and random flips of the same bit XOR, so the bit is restored. This still counts as corrupted, because the mask is nonzero before XOR.
- en=0: q holds, no corruption, pending is kept, err_pulse=0.
- err_pulse: registered; 1 for one cycle after an enabled capture whose combined pre-XOR mask (rand_mask | dir_mask) was nonzero.
- err_count: +1 on each err_pulse-setting edge and saturates at all-ones. clr_count takes priority over an increment on the same edge.
- Latency: d -> q is 1 cycle. Reset mid-operation drops pending injections and the count immediately.

Test Plan:
- Reset, mode=0, en=1, d=8'h5A for 100 cycles -> q=8'h5A one cycle after each d; err_pulse never high; err_count=0.
- mode=3, inject_idx=3 with valid one cycle, then en=1, d=8'h00 -> q=8'h08 exactly once; inject_ready low for one cycle, then high; err_count=1.
- mode=1, rate=20'hFFFFF, seed_load with seed=32'h1234_5678, d=0 for 1000 cycles -> every q is one-hot at the bit the reference LFSR model predicts; err_count=1000 (or 999, if the LFSR hits r=20'hFFFFF).
- mode=2, WIDTH=8, BURST_LEN=3, force a draw with pos=7 via a chosen seed, d=0 -> q=8'h83.
- COUNT_W=4, rate=20'hFFFFF for 40 cycles -> err_count sticks at 4'hF; clr_count with a hit on the same edge -> err_count=0.
- Same seed loaded in two runs -> identical q traces. Assert reset_n mid-run with an injection pending -> inject_ready=1 and q=0 immediately, and no flip after release.
